// File: rtl/pm_pkg.sv
// Shared constants and FSM encoding for the path-metric scheduler.
package pm_pkg;

    localparam int PM_W     = 7;
    localparam int NUM_ST   = 4;
    localparam int ID_W     = 3;
    localparam int NORM_BIT = PM_W - 1;

    typedef logic [1:0] pm_state_t;

    localparam pm_state_t ST_IDLE  = 2'd0;
    localparam pm_state_t ST_SWEEP = 2'd1;
    localparam pm_state_t ST_DRAIN = 2'd2;
    localparam pm_state_t ST_TERM  = 2'd3;

    // Metric MSB marks the upper half of the range; normalization keys off it.
    function automatic int norm_bit(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/pm_norm_chk.sv
// Collects the MSB of each returned path metric and reports whether all states
// are in the upper half, counting a return that arrives in the same cycle.
module pm_norm_chk #(
    parameter int NUM_ST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vld,
    input  logic [1:0] i_addr,
    input  logic       i_msb,
    input  logic       i_clr,
    output logic       o_all_high
);

    logic [NUM_ST-1:0] r_high;
    logic [NUM_ST-1:0] w_merged;

    always_comb begin
        w_merged = r_high;
        for (int i = 0; i < NUM_ST; i++) begin
            if (i_vld && (i_addr == 2'(i))) w_merged[i] = i_msb;
        end
    end

    assign o_all_high = &w_merged;

    // Clear wins over a coincident return: the DRAIN return is consumed by o_all_high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)      r_high <= '0;
        else if (i_clr) r_high <= '0;
        else            r_high <= w_merged;
    end

endmodule

// File: rtl/pm_sched.sv
// ACS sweep scheduler: issues one state update per cycle per symbol, tracks
// metric normalization and launches traceback on block termination.
module pm_sched #(
    parameter int PM_W   = pm_pkg::PM_W,
    parameter int NUM_ST = pm_pkg::NUM_ST,
    parameter int ID_W   = pm_pkg::ID_W
) (
    input  logic            PM_clk,
    input  logic            PM_rst,
    input  logic            sym_valid,
    input  logic [ID_W-1:0] sym_id,
    input  logic            sym_term,
    output logic            sym_ready,
    output logic            acs_en,
    output logic [1:0]      acs_addr,
    output logic [ID_W-1:0] acs_id,
    output logic            acs_term,
    output logic            acs_norm,
    input  logic            pm_vld,
    input  logic [1:0]      pm_addr,
    input  logic [PM_W-1:0] pm_in,
    output logic            tb_start,
    output logic [ID_W-1:0] tb_id,
    output logic            seq_err
);

    import pm_pkg::*;

    localparam logic [1:0] LAST_ADDR = 2'(NUM_ST - 1);
    localparam int         MSB       = norm_bit(PM_W);

    pm_state_t       r_state;
    logic [1:0]      r_addr;
    logic [ID_W-1:0] r_id;
    logic            r_term;
    logic            r_norm;
    logic            r_norm_pend;
    logic            r_prev_en;
    logic [1:0]      r_prev_addr;
    logic            r_seq_err;
    logic            w_acs_en;
    logic            w_all_high;
    logic            w_drain;
    logic            w_unused_pm;

    assign w_acs_en    = (r_state == ST_SWEEP);
    assign w_drain     = (r_state == ST_DRAIN);
    assign w_unused_pm = ^pm_in;

    assign sym_ready = (r_state == ST_IDLE) && !PM_rst;
    assign acs_en    = w_acs_en;
    assign acs_addr  = r_addr;
    assign acs_id    = r_id;
    assign acs_term  = r_term;
    assign acs_norm  = r_norm;
    assign tb_start  = (r_state == ST_TERM);
    assign tb_id     = r_id;
    assign seq_err   = r_seq_err;

    pm_norm_chk #(.NUM_ST(NUM_ST)) u_norm_chk (
        .i_clk      (PM_clk),
        .i_rst      (PM_rst),
        .i_vld      (pm_vld),
        .i_addr     (pm_addr),
        .i_msb      (pm_in[MSB]),
        .i_clr      (w_drain),
        .o_all_high (w_all_high)
    );

    always_ff @(posedge PM_clk or posedge PM_rst) begin
        if (PM_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_id        <= '0;
            r_term      <= 1'b0;
            r_norm      <= 1'b0;
            r_norm_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sym_valid) begin
                        r_id    <= sym_id;
                        r_term  <= sym_term;
                        r_norm  <= r_norm_pend;
                        r_addr  <= '0;
                        r_state <= ST_SWEEP;
                    end
                end
                // Counter parks on the last address so acs_addr holds outside SWEEP.
                ST_SWEEP: begin
                    if (r_addr == LAST_ADDR) r_state <= ST_DRAIN;
                    else                     r_addr  <= r_addr + 2'd1;
                end
                ST_DRAIN: begin
                    r_norm_pend <= w_all_high;
                    r_state     <= r_term ? ST_TERM : ST_IDLE;
                end
                ST_TERM: begin
                    r_norm_pend <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Each return must echo the address issued on the previous cycle.
    always_ff @(posedge PM_clk or posedge PM_rst) begin
        if (PM_rst) begin
            r_prev_en   <= 1'b0;
            r_prev_addr <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            r_prev_en   <= w_acs_en;
            r_prev_addr <= r_addr;
            if (pm_vld && (!r_prev_en || (pm_addr != r_prev_addr))) r_seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pm_sched.sv
// Scoreboard bench for pm_sched: expected ACS issues and traceback pulses are
// queued at symbol accept and consumed as the DUT produces them.
module tb_pm_sched;

    typedef struct packed {
        logic [1:0] addr;
        logic [2:0] id;
        logic       term;
        logic       norm;
    } exp_t;

    logic       PM_clk = 1'b0;
    logic       PM_rst;
    logic       sym_valid;
    logic [2:0] sym_id;
    logic       sym_term;
    logic       sym_ready;
    logic       acs_en;
    logic [1:0] acs_addr;
    logic [2:0] acs_id;
    logic       acs_term;
    logic       acs_norm;
    logic       pm_vld;
    logic [1:0] pm_addr;
    logic [6:0] pm_in;
    logic       tb_start;
    logic [2:0] tb_id;
    logic       seq_err;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t       exp_q[$];
    logic [2:0] tb_q[$];
    logic [3:0] high;
    logic       exp_norm;
    logic       exp_err;

    pm_sched dut (
        .PM_clk    (PM_clk),
        .PM_rst    (PM_rst),
        .sym_valid (sym_valid),
        .sym_id    (sym_id),
        .sym_term  (sym_term),
        .sym_ready (sym_ready),
        .acs_en    (acs_en),
        .acs_addr  (acs_addr),
        .acs_id    (acs_id),
        .acs_term  (acs_term),
        .acs_norm  (acs_norm),
        .pm_vld    (pm_vld),
        .pm_addr   (pm_addr),
        .pm_in     (pm_in),
        .tb_start  (tb_start),
        .tb_id     (tb_id),
        .seq_err   (seq_err)
    );

    always #5 PM_clk = ~PM_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge PM_clk) begin : mon
        exp_t       e;
        logic [2:0] t;
        if (!PM_rst) begin
            if (acs_en) begin
                if (exp_q.size() == 0) check("acs_unexpected", 32'(acs_en), 0);
                else begin
                    e = exp_q.pop_front();
                    check("acs_addr", 32'(acs_addr), 32'(e.addr));
                    check("acs_id",   32'(acs_id),   32'(e.id));
                    check("acs_term", 32'(acs_term), 32'(e.term));
                    check("acs_norm", 32'(acs_norm), 32'(e.norm));
                end
            end
            if (tb_start) begin
                if (tb_q.size() == 0) check("tb_unexpected", 32'(tb_start), 0);
                else begin
                    t = tb_q.pop_front();
                    check("tb_id", 32'(tb_id), 32'(t));
                end
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic run_sym(input logic [2:0] id, input logic term, input logic [27:0] pmv, input int bad_k);
        logic [1:0] a;
        logic [6:0] p;
        logic       all;
        check("sym_ready_idle", 32'(sym_ready), 1);
        sym_valid = 1'b1; sym_id = id; sym_term = term;
        for (int k = 0; k < 4; k++) exp_q.push_back('{addr: 2'(k), id: id, term: term, norm: exp_norm});
        @(posedge PM_clk); #1;
        sym_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("acs_en_sweep", 32'(acs_en), 1);
            check("sym_ready_busy", 32'(sym_ready), 0);
            @(posedge PM_clk); #1;
            a = (k == bad_k) ? 2'(k + 1) : 2'(k);
            p = pmv[k*7 +: 7];
            pm_vld = 1'b1; pm_addr = a; pm_in = p;
            high[a] = p[6];
            if (k == bad_k) exp_err = 1'b1;
        end
        check("acs_en_drain", 32'(acs_en), 0);
        check("issue_count", 32'(exp_q.size()), 0);
        all  = &high;
        high = '0;
        if (term) tb_q.push_back(id);
        @(posedge PM_clk); #1;
        pm_vld = 1'b0;
        exp_norm = term ? 1'b0 : all;
        check("tb_start_t6", 32'(tb_start), 32'(term));
        check("seq_err", 32'(seq_err), 32'(exp_err));
        if (term) begin
            @(posedge PM_clk); #1;
            check("tb_start_once", 32'(tb_start), 0);
        end
        check("sym_ready_next", 32'(sym_ready), 1);
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PM_rst = 1'b1; sym_valid = 1'b0; sym_id = '0; sym_term = 1'b0;
        pm_vld = 1'b0; pm_addr = '0; pm_in = '0;
        high = '0; exp_norm = 1'b0; exp_err = 1'b0;
        #12;
        check("rst_sym_ready", 32'(sym_ready), 0);
        check("rst_acs_en",    32'(acs_en),    0);
        check("rst_acs_addr",  32'(acs_addr),  0);
        check("rst_tb_start",  32'(tb_start),  0);
        check("rst_seq_err",   32'(seq_err),   0);
        @(negedge PM_clk); PM_rst = 1'b0;
        @(posedge PM_clk); #1;

        run_sym(3'd5, 1'b0, {4{7'h10}}, -1);
        run_sym(3'd1, 1'b0, {4{7'h45}}, -1);
        run_sym(3'd2, 1'b0, {4{7'h10}}, -1);
        run_sym(3'd4, 1'b0, {7'h45, 7'h3F, 7'h45, 7'h45}, -1);
        run_sym(3'd6, 1'b0, {4{7'h10}}, -1);
        run_sym(3'd7, 1'b0, {4{7'h45}}, -1);
        run_sym(3'd3, 1'b1, {4{7'h45}}, -1);
        run_sym(3'd0, 1'b0, {4{7'h10}}, -1);
        run_sym(3'd2, 1'b0, {4{7'h10}}, 1);
        run_sym(3'd1, 1'b0, {4{7'h45}}, -1);
        check("seq_err_sticky", 32'(seq_err), 1);

        // Reset during a terminating sweep with norm pending.
        check("sym_ready_pre_rst", 32'(sym_ready), 1);
        sym_valid = 1'b1; sym_id = 3'd5; sym_term = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back('{addr: 2'(k), id: 3'd5, term: 1'b1, norm: exp_norm});
        @(posedge PM_clk); #1;
        sym_valid = 1'b0;
        @(posedge PM_clk); #1;
        pm_vld = 1'b1; pm_addr = 2'd0; pm_in = 7'h45;
        #2;
        PM_rst = 1'b1; pm_vld = 1'b0;
        exp_q.delete();
        high = '0; exp_norm = 1'b0; exp_err = 1'b0;
        #1;
        check("mid_rst_acs_en",   32'(acs_en),    0);
        check("mid_rst_acs_addr", 32'(acs_addr),  0);
        check("mid_rst_acs_id",   32'(acs_id),    0);
        check("mid_rst_acs_term", 32'(acs_term),  0);
        check("mid_rst_acs_norm", 32'(acs_norm),  0);
        check("mid_rst_tb_id",    32'(tb_id),     0);
        check("mid_rst_seq_err",  32'(seq_err),   0);
        check("mid_rst_ready",    32'(sym_ready), 0);
        @(posedge PM_clk);
        @(negedge PM_clk); PM_rst = 1'b0;
        @(posedge PM_clk); #1;
        check("rel_sym_ready", 32'(sym_ready), 1);
        check("rel_tb_start",  32'(tb_start),  0);

        run_sym(3'd6, 1'b0, {4{7'h10}}, -1);
        repeat (3) @(posedge PM_clk);
        #1;
        check("tb_q_empty",  32'(tb_q.size()),  0);
        check("exp_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pm_sched.md
PM_SCHED -- requirements
Module: pm_sched

Interface
REQ-001 SHALL have parameter PM_W, default 7, path-metric width.
REQ-002 SHALL have parameter NUM_ST, default 4, trellis states swept per symbol.
REQ-003 SHALL have parameter ID_W, default 3, data-id width.
REQ-004 SHALL have port PM_clk, input, 1: the only clock.
REQ-005 SHALL have port PM_rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port sym_valid, input, 1: a symbol is offered.
REQ-007 SHALL have port sym_id, input, ID_W: id of the offered symbol.
REQ-008 SHALL have port sym_term, input, 1: the offered symbol is the last of its block.
REQ-009 SHALL have port sym_ready, output, 1: the scheduler accepts a symbol.
REQ-010 SHALL have port acs_en, output, 1: ACS issue strobe.
REQ-011 SHALL have port acs_addr, output, 2: trellis state being updated.
REQ-012 SHALL have port acs_id, output, ID_W: id tagged on the issue.
REQ-013 SHALL have port acs_term, output, 1: term tagged on the issue.
REQ-014 SHALL have port acs_norm, output, 1: ACS subtracts 2^(PM_W-1) this sweep.
REQ-015 SHALL have port pm_vld, input, 1: a path metric returns from the PM register stage.
REQ-016 SHALL have port pm_addr, input, 2: state of the returned metric.
REQ-017 SHALL have port pm_in, input, PM_W: returned path metric.
REQ-018 SHALL have port tb_start, output, 1: one-cycle traceback start pulse.
REQ-019 SHALL have port tb_id, output, ID_W: id of the terminated block.
REQ-020 SHALL have port seq_err, output, 1: sticky sequencing error.

Function
REQ-021 SHALL implement FSM states IDLE, SWEEP, DRAIN and TERM.
REQ-022 IDLE SHALL drive sym_ready=1; on sym_valid it SHALL latch sym_id/sym_term, clear the address counter and go to SWEEP; every other state SHALL drive sym_ready=0.
REQ-023 SWEEP SHALL drive acs_en=1 for exactly NUM_ST consecutive cycles with acs_addr 0,1,2,3, and acs_id, acs_term, acs_norm held constant at the latched values.
REQ-024 SWEEP SHALL go to DRAIN on the cycle after acs_addr=NUM_ST-1 is issued.
REQ-025 pm_vld is expected exactly one cycle after each issue; on pm_vld the block SHALL record high[pm_addr] = pm_in[PM_W-1].
REQ-026 DRAIN SHALL last one cycle, accept the last return, set norm_pending = AND of all high bits (including that return), and clear high[].
REQ-027 DRAIN SHALL go to TERM if the latched term=1, otherwise to IDLE.
REQ-028 acs_norm for a sweep SHALL equal the norm_pending value at SWEEP entry; norm_pending SHALL change only in DRAIN and TERM.
REQ-029 TERM SHALL pulse tb_start=1 with tb_id equal to the latched id for one cycle, clear norm_pending, and go to IDLE.
REQ-030 Latency SHALL be: accept at cycle T, issues at T+1..T+4, DRAIN at T+5, TERM at T+6 if term; the next accept SHALL occur at T+6 (non-term) or T+7 (term) at the earliest.
REQ-031 seq_err SHALL set on pm_vld whose pm_addr differs from the address issued one cycle earlier, or on any pm_vld not preceded by acs_en; it SHALL clear only on reset.
REQ-032 seq_err SHALL not stall the FSM.
REQ-033 Outside SWEEP, acs_en SHALL be 0; acs_addr, acs_id and acs_term SHALL hold their last values.

Reset
REQ-034 PM_rst=1 SHALL asynchronously force: state IDLE, sym_ready=0 while reset is asserted, acs_en=0, acs_addr=0, acs_id=0, acs_term=0, acs_norm=0, tb_start=0, tb_id=0, seq_err=0, norm_pending=0, high[]=0.
REQ-035 Reset asserted mid-sweep SHALL abandon the symbol without a tb_start pulse; sym_ready SHALL be 1 on the first clock after release.

Structure
REQ-036 The shared package pm_pkg SHALL hold the FSM state type, PM_W, NUM_ST, ID_W and the normalization bit index.
REQ-037 The high-bit collection and AND reduction SHALL be the sub-module pm_norm_chk; all other logic SHALL be flat.

Verification
REQ-038 The bench SHALL cover: single symbol id=5, term=0, returns pm=0x10 -> acs_addr 0..3 on T+1..T+4, acs_norm=0, no tb_start, sym_ready high at T+6.
REQ-039 The bench SHALL cover: symbol A with all returns 0x45 followed by symbol B -> A acs_norm=0, B acs_norm=1 on all four issues.
REQ-040 The bench SHALL cover: returns 0x45,0x45,0x3F,0x45 -> next sweep acs_norm=0.
REQ-041 The bench SHALL cover: id=3, term=1 -> tb_start=1 and tb_id=3 at T+6 only, next sweep acs_norm=0.
REQ-042 The bench SHALL cover: pm_addr=2 returned when 1 expected -> seq_err=1, held until reset, sweep completes normally.
REQ-043 The bench SHALL cover: PM_rst pulsed at T+2 -> all outputs reset immediately, no tb_start, sym_ready=1 on the first clock after release.
